// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives operands and START. The slave returns the result and status.
interface serial_sub_if #(parameter int WIDTH = 4) ();
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             BUSY;
  logic             DONE;

  modport master (output START, A, B, BIN, input D, BOUT, BUSY, DONE);
  modport slave  (input START, A, B, BIN, output D, BOUT, BUSY, DONE);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor. It processes one bit per cycle, LSB first, through a registered borrow.
// D and BOUT load only on the completing edge, so partial results never appear on them.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, d_q;
  logic             bw_q, bout_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic             dbit_d, bw_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    dbit_d = a_q[0] ^ b_q[0] ^ bw_q;
    bw_d   = (~a_q[0] & b_q[0]) | (~a_q[0] & bw_q) | (b_q[0] & bw_q);
    acc_d  = {dbit_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            bw_q    <= bus.BIN;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // START is deliberately not examined here, so a request mid-operation is dropped.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bw_q  <= bw_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            d_q     <= acc_d;
            bout_q  <= bw_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          if (bus.START) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            bw_q    <= bus.BIN;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.D    = d_q;
  assign bus.BOUT = bout_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=4.
// The stimulus pushes the expected {BOUT,D}, and a negedge monitor pops and compares on each DONE.
module tb_serial_sub;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  logic [W:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every DONE outside reset must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && bus.DONE === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 32'(done_cnt), 32'd0);
      else check("result", 32'({bus.BOUT, bus.D}), 32'(sb.pop_front()));
    end
  end

  // Issue one operation and wait for DONE.
  // lat counts edges from the START edge to the DONE edge. bn counts BUSY cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W:0] exp, output int lat, output int bn);
    int k;
    k = 0; bn = 0; lat = -1;
    @(negedge CLK);
    bus.A = a; bus.B = b; bus.BIN = bin; bus.START = 1'b1;
    sb.push_back(exp);
    while (k < 20) begin
      @(negedge CLK);
      k++;
      if (k == 1) bus.START = 1'b0;
      if (bus.BUSY === 1'b1) bn++;
      if (bus.DONE === 1'b1) begin lat = k - 1; break; end
    end
    if (lat < 0) check("done_timeout", 32'(k), 32'd0);
  endtask

  initial begin
    int lat, bn, d0, k1, k2;
    logic [W:0] m;
    bus.START = 1'b0; bus.A = '0; bus.B = '0; bus.BIN = 1'b0;
    #12;
    check("rst_D", 32'(bus.D), 32'd0);
    check("rst_BOUT", 32'(bus.BOUT), 32'd0);
    check("rst_BUSY", 32'(bus.BUSY), 32'd0);
    check("rst_DONE", 32'(bus.DONE), 32'd0);
    @(negedge CLK); RST = 1'b0;

    // 9-3: latency 4 edges, BUSY 4 cycles
    run_op(4'd9, 4'd3, 1'b0, {1'b0, 4'd6}, lat, bn);
    check("lat_9_3", 32'(lat), 32'd4);
    check("busy_9_3", 32'(bn), 32'd4);

    run_op(4'd3, 4'd9, 1'b0, {1'b1, 4'hA}, lat, bn);
    run_op(4'd0, 4'd0, 1'b1, {1'b1, 4'hF}, lat, bn);
    run_op(4'hF, 4'hF, 1'b1, {1'b1, 4'hF}, lat, bn);

    // D/BOUT hold through idle
    repeat (5) @(negedge CLK);
    check("hold_D", 32'(bus.D), 32'hF);
    check("hold_BOUT", 32'(bus.BOUT), 32'd1);

    // Operand change and START during RUN are both ignored.
    d0 = done_cnt;
    @(negedge CLK);
    bus.A = 4'd8; bus.B = 4'd1; bus.BIN = 1'b0; bus.START = 1'b1;
    sb.push_back({1'b0, 4'd7});
    @(negedge CLK); bus.START = 1'b0;
    @(negedge CLK); bus.A = 4'd0; bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    repeat (12) @(negedge CLK);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("idle_after_ignored", 32'(bus.BUSY), 32'd0);

    // START held high: 5-2 then 2-5, so the two DONE pulses are 5 cycles apart.
    k1 = -1; k2 = -1;
    @(negedge CLK);
    bus.A = 4'd5; bus.B = 4'd2; bus.BIN = 1'b0; bus.START = 1'b1;
    sb.push_back({1'b0, 4'd3});
    sb.push_back({1'b1, 4'hD});
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) begin bus.A = 4'd2; bus.B = 4'd5; end
      if (k == 6) bus.START = 1'b0;
      if (bus.DONE === 1'b1) begin
        if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
      end
    end
    check("b2b_first", 32'(k1), 32'd5);
    check("b2b_spacing", 32'(k2 - k1), 32'd5);

    // Asynchronous reset in the third RUN cycle aborts the operation.
    d0 = done_cnt;
    @(negedge CLK);
    bus.A = 4'd9; bus.B = 4'd4; bus.BIN = 1'b0; bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #3;
    check("pre_rst_busy", 32'(bus.BUSY), 32'd1);
    check("pre_rst_D", 32'(bus.D), 32'hD);
    RST = 1'b1; #1;
    check("async_D", 32'(bus.D), 32'd0);
    check("async_BOUT", 32'(bus.BOUT), 32'd0);
    check("async_BUSY", 32'(bus.BUSY), 32'd0);
    check("async_DONE", 32'(bus.DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    run_op(4'd7, 4'd7, 1'b0, {1'b0, 4'd0}, lat, bn);
    check("lat_7_7", 32'(lat), 32'd4);

    // Exhaustive sweep against the arithmetic model.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          m = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(c);
          run_op(4'(a), 4'(b), 1'(c), m, lat, bn);
        end

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d, expected finish", total_cnt);
    $fatal(1);
  end
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port BIN, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port D, output, WIDTH bits: registered difference.
REQ-009 The block SHALL have port BOUT, output, 1 bit: registered borrow-out.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while the operation is in progress.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 The block SHALL compute {BOUT, D} such that D = (A - B - BIN) mod 2^WIDTH and BOUT = 1 exactly when A < B + BIN.
REQ-013 The block SHALL compute one bit per cycle, LSB first, using a registered borrow: d_i = a_i ^ b_i ^ bw; bw_next = (~a_i & b_i) | (~a_i & bw) | (b_i & bw); bw is initialised from BIN.
REQ-014 The block SHALL implement FSM states IDLE, RUN and FIN, with IDLE as the reset state.
REQ-015 In IDLE, the block SHALL, on START=1 at an edge, capture A, B and BIN into internal registers, clear the bit counter and enter RUN; with START=0 it SHALL remain in IDLE.
REQ-016 In RUN, the block SHALL process one bit per edge; on the edge processing bit WIDTH-1 it SHALL load D and BOUT and enter FIN.
REQ-017 In FIN, the block SHALL, on START=1, capture new operands and enter RUN; otherwise it SHALL return to IDLE.
REQ-018 BUSY SHALL be 1 exactly while in RUN; DONE SHALL be 1 exactly while in FIN, for one cycle per operation.
REQ-019 Latency SHALL be WIDTH cycles: with START sampled at edge t0, DONE=1 and D/BOUT valid after edge t0+WIDTH.
REQ-020 Back-to-back throughput SHALL be one result per WIDTH+1 cycles when START is held high.
REQ-021 START while BUSY=1 SHALL be ignored, with no effect on the operation in progress or on its result.
REQ-022 Changes on A, B or BIN after capture SHALL NOT affect the operation in progress.
REQ-023 D and BOUT SHALL hold their last loaded values until the next completion, including through IDLE periods.
REQ-024 Partial results SHALL never appear on D or BOUT; D and BOUT SHALL change only on the completing edge or on reset.

Reset
REQ-025 When RST=1, the block SHALL immediately, without waiting for CLK, force state=IDLE, D=0, BOUT=0, BUSY=0 and DONE=0, and clear the operand, borrow and counter registers.
REQ-026 Reset asserted during RUN SHALL abort the operation: no DONE pulse follows, and the first START after RST deasserts SHALL begin a clean operation.

Verification
REQ-027 (WIDTH=4) The bench SHALL apply A=9, B=3, BIN=0, START pulse -> D=6, BOUT=0, DONE high exactly 4 edges after the START edge, BUSY high for 4 cycles.
REQ-028 The bench SHALL apply A=3, B=9, BIN=0 -> D=4'hA, BOUT=1; then A=0, B=0, BIN=1 -> D=4'hF, BOUT=1; then A=F, B=F, BIN=1 -> D=4'hF, BOUT=1.
REQ-029 The bench SHALL start A=8, B=1, then change A to 0 and pulse START at the second RUN cycle -> D=7, BOUT=0, a single DONE, and the second START ignored.
REQ-030 The bench SHALL hold START=1 with operands 5-2 then 2-5 -> DONE pulses 5 cycles apart; results 3/0, then 4'hD/1.
REQ-031 The bench SHALL assert RST asynchronously mid-cycle during the third RUN cycle -> outputs 0 at once, no DONE; after release, 7-7, BIN=0 -> D=0, BOUT=0.
REQ-032 The bench SHALL run an exhaustive sweep of A, B and BIN at WIDTH=4, checking D and BOUT against the arithmetic model on every DONE.
